modulo_seq_ctrl: RTL and testbench

//  Sequencer for the modulo-5 datapath: takes a WIDTH-bit value on a valid/ready port.

---
 rtl/modulo_seq_pkg.sv | 21 ++
 rtl/modulo_seq_if.sv | 25 ++
 rtl/modulo_seq_counter.sv | 28 ++
 rtl/modulo_seq_ctrl.sv | 116 +++++++++++
 tb/tb_modulo_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/modulo_seq_pkg.sv
// Shared types and constants for the modulo-5 conversion sequencer.
// Optional build macro used by the sequencer: MODULO_SEQ_COUNT_EN.
package modulo_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } seq_state_t;

  localparam int REM_W   = 3;
  localparam int MODULUS = 5;

  // Enabled shift cycles per conversion: pipeline fill plus one per operand bit.
  function automatic int shift_cycles(input int width, input int pipe_lat);
    return width + pipe_lat;
  endfunction

endpackage

// File: rtl/modulo_seq_if.sv
// Operand and result valid/ready ports of the modulo-5 sequencer.
// master = producer/consumer side, slave = the sequencer itself.
interface modulo_seq_if #(
  parameter int WIDTH = 8
) ();
  import modulo_seq_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             result_valid;
  logic             result_ready;
  logic [REM_W-1:0] result;

  modport master (
    output in_valid, in_value, result_ready,
    input  in_ready, result_valid, result
  );

  modport slave (
    input  in_valid, in_value, result_ready,
    output in_ready, result_valid, result
  );

endinterface

// File: rtl/modulo_seq_counter.sv
// Down counter that measures the SHIFT phase: loaded with N-1, last when it reaches 0.
module modulo_seq_counter #(
  parameter int N = 9
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic last
);

  localparam int W = $clog2(N + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(N - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/modulo_seq_ctrl.sv
// Sequencer for the modulo-5 datapath: load/shift the operand register, clear/enable the detector,
// capture the remainder. Define MODULO_SEQ_COUNT_EN to add the conv_count conversion counter.
module modulo_seq_ctrl
  import modulo_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PIPE_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  modulo_seq_if.slave      bus,
  output logic             busy,
  output logic [WIDTH-1:0] reg_parallel_in,
  output logic             reg_catch_in,
  output logic             reg_en,
  output logic             det_reset,
  output logic             det_en,
  input  logic [REM_W-1:0] det_remainder
`ifdef MODULO_SEQ_COUNT_EN
  ,
  output logic [15:0]      conv_count
`endif
);

  localparam int N = shift_cycles(WIDTH, PIPE_LAT);

  seq_state_t       state_q, state_d;
  logic             cnt_last;
  logic             in_ready_q;
  logic             busy_q;
  logic             catch_q;
  logic             reg_en_q;
  logic             det_reset_q;
  logic             det_en_q;
  logic             result_valid_q;
  logic [REM_W-1:0] result_q;
  logic [WIDTH-1:0] operand_q;

  modulo_seq_counter #(
    .N (N)
  ) u_shift_cnt (
    .clock (clock),
    .reset (reset),
    .load  (state_q == LOAD),
    .en    (state_q == SHIFT),
    .last  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_last) state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    if (bus.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every strobe is decoded from the next state so it is a flop output aligned with its state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
      catch_q        <= 1'b0;
      reg_en_q       <= 1'b0;
      det_reset_q    <= 1'b0;
      det_en_q       <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      operand_q      <= '0;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= (state_d == IDLE);
      busy_q         <= (state_d != IDLE);
      catch_q        <= (state_d == LOAD);
      reg_en_q       <= (state_d == LOAD) || (state_d == SHIFT);
      det_reset_q    <= (state_d == LOAD);
      det_en_q       <= (state_d == SHIFT);
      result_valid_q <= (state_d == DONE);
      if ((state_q == IDLE) && bus.in_valid) begin
        operand_q <= bus.in_value;
      end
      if (state_q == CAPTURE) begin
        result_q <= det_remainder;
      end
    end
  end

`ifdef MODULO_SEQ_COUNT_EN
  logic [15:0] conv_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      conv_count_q <= '0;
    end else if ((state_q == DONE) && bus.result_ready) begin
      conv_count_q <= conv_count_q + 16'd1;
    end
  end

  assign conv_count = conv_count_q;
`endif

  assign bus.in_ready     = in_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign busy             = busy_q;
  assign reg_parallel_in  = operand_q;
  assign reg_catch_in     = catch_q;
  assign reg_en           = reg_en_q;
  assign det_reset        = det_reset_q;
  assign det_en           = det_en_q;

endmodule

// File: tb/tb_modulo_seq_ctrl.sv
// Bench for modulo_seq_ctrl with behavioural shift-register and serial mod-5 detector models.
// Honours MODULO_SEQ_COUNT_EN when the build defines it.
module tb_modulo_seq_ctrl;

  localparam int WIDTH    = 8;
  localparam int PIPE_LAT = 1;
  localparam int N        = WIDTH + PIPE_LAT;
  // Edges from accept until the consumer first samples result_valid high.
  localparam int LAT      = N + 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             busy;
  logic [WIDTH-1:0] reg_parallel_in;
  logic             reg_catch_in, reg_en, det_reset, det_en;
  logic [2:0]       det_remainder;
`ifdef MODULO_SEQ_COUNT_EN
  logic [15:0]      conv_count;
`endif

  int errors = 0;
  int checks = 0;
  int exp_conv = 0;

  modulo_seq_if #(.WIDTH(WIDTH)) bus ();

  modulo_seq_ctrl #(
    .WIDTH    (WIDTH),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clock           (clk),
    .reset           (reset),
    .bus             (bus),
    .busy            (busy),
    .reg_parallel_in (reg_parallel_in),
    .reg_catch_in    (reg_catch_in),
    .reg_en          (reg_en),
    .det_reset       (det_reset),
    .det_en          (det_en),
    .det_remainder   (det_remainder)
`ifdef MODULO_SEQ_COUNT_EN
    ,
    .conv_count      (conv_count)
`endif
  );

  always #5 clk = ~clk;

  // Environment: parallel-in shift register (MSB first), one pipeline bit, serial mod-5 detector.
  logic [WIDTH-1:0] sr;
  logic             pipe_bit;
  always @(posedge clk) begin
    if (reset) begin
      sr            <= '0;
      pipe_bit      <= 1'b0;
      det_remainder <= 3'd0;
    end else begin
      if (reg_en) begin
        if (reg_catch_in) begin
          sr       <= reg_parallel_in;
          pipe_bit <= 1'b0;
        end else begin
          sr       <= {sr[WIDTH-2:0], 1'b0};
          pipe_bit <= sr[WIDTH-1];
        end
      end
      if (det_reset) det_remainder <= 3'd0;
      else if (det_en) det_remainder <= 3'((2 * int'(det_remainder) + int'(pipe_bit)) % 5);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One conversion from IDLE; result_ready held low for 'delay' cycles of DONE.
  task automatic run_conv(input logic [7:0] v, input int delay, input int exp_rem);
    int k;
    int en_cycles;
    int held;
    chk("idle_in_ready", int'(bus.in_ready), 1);
    bus.in_valid     = 1'b1;
    bus.in_value     = v;
    bus.result_ready = (delay == 0);
    step();
    bus.in_valid = 1'b0;
    bus.in_value = 8'($urandom);
    chk("operand_latched", int'(reg_parallel_in), int'(v));
    chk("load_strobes", int'({reg_catch_in, reg_en, det_reset, det_en}), 'b1110);
    chk("busy_after_accept", int'(busy), 1);
    k = 0;
    en_cycles = 0;
    while (!bus.result_valid && k < 64) begin
      chk("in_ready_while_busy", int'(bus.in_ready), 0);
      if (det_en) en_cycles++;
      step();
      k++;
    end
    $display("conv in=%0d latency=%0d result=%0d expected=%0d", v, k + 1, bus.result, exp_rem);
    chk("latency", k + 1, LAT);
    chk("shift_cycles", en_cycles, N);
    chk("result", int'(bus.result), exp_rem);
    chk("done_strobes", int'({reg_catch_in, reg_en, det_reset, det_en}), 0);
    held = int'(bus.result);
    for (int d = 0; d < delay; d++) begin
      bus.in_valid = 1'b1;
      bus.in_value = ~v;
      step();
      chk("hold_valid", int'(bus.result_valid), 1);
      chk("hold_result", int'(bus.result), held);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("ignored_operand", int'(reg_parallel_in), int'(v));
    end
    bus.in_valid     = 1'b0;
    bus.result_ready = 1'b1;
    step();
    exp_conv++;
    bus.result_ready = 1'b0;
    chk("released_valid", int'(bus.result_valid), 0);
    chk("back_in_ready", int'(bus.in_ready), 1);
    chk("back_not_busy", int'(busy), 0);
  endtask

  // in_valid and result_ready held high; accepts must be N+4 cycles apart.
  task automatic run_stream(input logic [7:0] v, input int n_accepts, input int exp_rem);
    int cyc = 0;
    int last_acc = -1;
    int accepts = 0;
    logic ir, rv;
    int res;
    bus.in_valid     = 1'b1;
    bus.in_value     = v;
    bus.result_ready = 1'b1;
    while (accepts < n_accepts && cyc < 500) begin
      ir  = bus.in_ready;
      rv  = bus.result_valid;
      res = int'(bus.result);
      if (rv) begin
        chk("stream_result", res, exp_rem);
        exp_conv++;
      end
      step();
      cyc++;
      if (ir) begin
        if (last_acc >= 0) begin
          $display("stream accept at cycle %0d period=%0d", cyc, cyc - last_acc);
          chk("stream_period", cyc - last_acc, N + 4);
        end
        last_acc = cyc;
        accepts++;
      end
    end
    chk("stream_accepts", accepts, n_accepts);
    bus.in_valid = 1'b0;
    cyc = 0;
    while (!bus.in_ready && cyc < 64) begin
      if (bus.result_valid) begin
        chk("stream_result", int'(bus.result), exp_rem);
        exp_conv++;
      end
      step();
      cyc++;
    end
    bus.result_ready = 1'b0;
    chk("stream_drained", int'(bus.in_ready), 1);
  endtask

  typedef struct {
    logic [7:0] value;
    int         ready_delay;
    int         exp_rem;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h07, 0, 2};
    vecs[1] = '{8'hFF, 5, 0};
    vecs[2] = '{8'h0D, 0, 3};
    vecs[3] = '{8'h0A, 1, 0};
    vecs[4] = '{8'h00, 2, 0};
    vecs[5] = '{8'hF9, 3, 4};

    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_value     = '0;
    bus.result_ready = 1'b0;
    repeat (3) step();
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_result_valid", int'(bus.result_valid), 0);
    chk("reset_result", int'(bus.result), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_strobes", int'({reg_catch_in, reg_en, det_reset, det_en}), 0);
    chk("reset_operand", int'(reg_parallel_in), 0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) run_conv(vecs[i].value, vecs[i].ready_delay, vecs[i].exp_rem);

    for (int x = 0; x < 256; x++) run_conv(8'(x), 0, x % 5);

    for (int r = 0; r < 30; r++) begin
      int v = int'($urandom_range(0, 255));
      run_conv(8'(v), int'($urandom_range(0, 3)), v % 5);
    end

    // Reset during the fourth SHIFT cycle drops the operand.
    bus.in_valid = 1'b1;
    bus.in_value = 8'hC3;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    chk("mid_shift_det_en", int'(det_en), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_conv = 0;
    chk("midreset_in_ready", int'(bus.in_ready), 1);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_valid", int'(bus.result_valid), 0);
    chk("midreset_strobes", int'({reg_catch_in, reg_en, det_reset, det_en}), 0);
    run_conv(8'h0A, 0, 0);
`ifdef MODULO_SEQ_COUNT_EN
    run_conv(8'h11, 1, 2);
    run_conv(8'h12, 0, 3);
    chk("conv_count_three", int'(conv_count), 3);
`endif

    run_stream(8'h0D, 4, 3);

`ifdef MODULO_SEQ_COUNT_EN
    chk("conv_count_total", int'(conv_count), exp_conv % 65536);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
